uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver: configurable data width, parity mode and stop-bit count, with 3-sample majority voting at mid-bit. Delivers each frame through a valid/ready output register with per-frame status flags (parity, framing, break) and overrun detection. Sits between the pad-side serial line and the byte/word consumer (FIFO or command decoder) in the receive clock domain.

Parameters:
clksPerBit, 16, rx clock cycles per bit period; legal range >= 8.
dataBits, 8, data bits per frame, 5..9, LSB first.
parityMode, 1, 0 = none, 1 = even, 2 = odd.
stopBits, 1, 1 or 2.

Ports:
i_clkRx  in  1  receive clock.
i_rstRx  in  1  asynchronous, active-high reset.
i_rxLine  in  1  asynchronous serial line, idle high.
o_rxData  out  dataBits  received word, valid while o_rxValid = 1.
o_rxValid  out  1  output register holds an unconsumed frame.
i_rxReady  in  1  consumer accepts; transfer occurs when o_rxValid & i_rxReady.
o_parityError  out  1  parity mismatch for the held frame; 0 when parityMode = 0.
o_frameError  out  1  any stop bit sampled 0 for the held frame.
o_break  out  1  break condition active.
o_overrun  out  1  one-cycle pulse when a completed frame is dropped.
o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, i_rstRx = 1): FSM to IDLE; synchroniser flops to 1; all outputs 0; o_rxData 0. Reset mid-frame discards the partial frame and produces no output.
- Input passes through a 2-flop synchroniser (2-cycle latency) and a 3-deep shift register. A bit value is the majority of the samples at counter = mid-1, mid, mid+1, where mid = clksPerBit/2. The bit counter is $clog2(clksPerBit) wide.
- IDLE: a synchronised 0 resets the counter and moves to START.
- START: at mid+1, majority = 1 is a false start and returns to IDLE with no output. Majority = 0 clears the counter and moves to DATA.
- DATA: every clksPerBit cycles, shift the majority bit in LSB-first. After dataBits bits, go to PARITY if parityMode != 0, otherwise to STOP.
- PARITY: sample one bit. Expected bit = XOR(data) for even parity, ~XOR(data) for odd. A mismatch sets the frame's parity flag.
- STOP: sample stopBits bits. Any 0 sets the frame's framing flag. Completion happens at the mid-point of the last stop bit. The FSM returns to IDLE on the next cycle, so back-to-back frames are supported with no hold time.
- Break: all data bits, the parity bit (if present) and the stop bits are 0 → set o_break and go to BRKWAIT. BRKWAIT waits for a synchronised 1, then clears o_break and returns to IDLE. A break frame is not delivered to o_rxData.
- Output register update, one cycle after completion:
  - Register empty, or register full with i_rxReady = 1 in the same cycle: load data and flags; o_rxValid = 1.
  - Register full with i_rxReady = 0: drop the new frame, keep the old data and flags, pulse o_overrun for 1 cycle.
- A handshake with no new frame clears o_rxValid on the next cycle. Flags are meaningful only while o_rxValid = 1.
- Frames with parity or framing errors are still delivered, with their flags set.
- Total latency from the line falling edge to o_rxValid is about (1 + dataBits + P + stopBits - 0.5)·clksPerBit + 4 cycles. The bench checks against a ±2-cycle window.

Decomposition:
- Shared package uart_pkg: PARITY_NONE/EVEN/ODD constants; FSM state encoding (IDLE, START, DATA, PARITY, STOP, BRKWAIT); bit-count width helper.
- Sub-module uart_rx_sampler: synchroniser, bit-period counter and majority vote. Outputs a one-cycle sample strobe plus the voted bit. The top level holds the FSM, shift register and output register.

Test Plan:
1. Defaults; send 0xA5 (parity bit 0, 1 stop bit), i_rxReady = 1 → o_rxData = 0xA5, o_rxValid pulses 1 cycle, all flags 0.
2. Send 0xA5 with parity bit 1 → o_parityError = 1 while valid. Repeat with stop bit 0 → o_frameError = 1. Data = 0xA5 in both cases.
3. i_rxReady = 0; send 0x3C then 0xC3 back-to-back → o_rxData stays 0x3C; o_overrun pulses once at 0xC3 completion. Raising ready then clears o_rxValid.
4. Line low for 4 cycles then high (glitch) → no o_rxValid and no flags; o_busy returns to 0 within clksPerBit cycles.
5. Line low for 12 bit periods, then high → o_break = 1 from the break detection point until 3 cycles after the line rises; no o_rxValid.
6. dataBits = 7, parityMode = 2, stopBits = 2; send 0x55 with a correct odd parity bit, then assert i_rstRx mid-way through a second frame → first frame delivered clean; after reset all outputs are 0 and the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and types for the UART receiver
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_BRKWAIT = 3'd5;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_flags_t;

    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchroniser, bit-period counter and 3-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int clksPerBit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    input  logic restart,
    output logic level,
    output logic strobe,
    output logic bit_value
);

    localparam int CW  = cnt_width(clksPerBit);
    localparam int MID = clksPerBit / 2;
    localparam logic [CW-1:0] LAST    = CW'(clksPerBit - 1);
    localparam logic [CW-1:0] VOTE_AT = CW'(MID + 1);

    logic [1:0]    sync;
    logic [1:0]    hist;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            hist <= 2'b11;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], line};
            hist <= {hist[0], sync[1]};
            if (restart || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // Window is {sample at mid-1, sample at mid, current sample at mid+1}.
    assign level     = sync[1];
    assign strobe    = (cnt == VOTE_AT);
    assign bit_value = (hist[1] & hist[0]) | (hist[1] & level) | (hist[0] & level);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output register
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int clksPerBit = 16,
    parameter int dataBits   = 8,
    parameter int parityMode = 1,
    parameter int stopBits   = 1
) (
    input  logic                i_clkRx,
    input  logic                i_rstRx,
    input  logic                i_rxLine,
    output logic [dataBits-1:0] o_rxData,
    output logic                o_rxValid,
    input  logic                i_rxReady,
    output logic                o_parityError,
    output logic                o_frameError,
    output logic                o_break,
    output logic                o_overrun,
    output logic                o_busy
);

    logic                level;
    logic                strobe;
    logic                bit_value;
    logic                restart;
    logic [2:0]          state;
    logic [dataBits-1:0] shift;
    logic [3:0]          bit_idx;
    logic                all_zero;
    logic                brk;
    logic                last_stop;
    logic                complete;
    rx_flags_t           flags;
    rx_flags_t           frame_flags;

    uart_rx_sampler #(.clksPerBit(clksPerBit)) u_sampler (
        .clk       (i_clkRx),
        .rst       (i_rstRx),
        .line      (i_rxLine),
        .restart   (restart),
        .level     (level),
        .strobe    (strobe),
        .bit_value (bit_value)
    );

    assign restart   = (state == ST_IDLE) && !level;
    assign last_stop = (state == ST_STOP) && strobe && (bit_idx == 4'(stopBits - 1));
    // A frame whose every bit after start was 0 is a break, never a delivered word.
    assign complete  = last_stop && !(all_zero && !bit_value);

    always_comb begin
        frame_flags           = flags;
        frame_flags.frame_err = flags.frame_err | ~bit_value;
    end

    always_ff @(posedge i_clkRx or posedge i_rstRx) begin
        if (i_rstRx) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            all_zero <= 1'b0;
            flags    <= '0;
            brk      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!level)
                        state <= ST_START;
                end
                ST_START: begin
                    if (strobe) begin
                        if (bit_value) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            all_zero <= 1'b1;
                            flags    <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shift    <= {bit_value, shift[dataBits-1:1]};
                        all_zero <= all_zero & ~bit_value;
                        if (bit_idx == 4'(dataBits - 1)) begin
                            bit_idx <= '0;
                            state   <= (parityMode != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        flags.parity_err <= bit_value != ((^shift) ^ (parityMode == PARITY_ODD));
                        all_zero         <= all_zero & ~bit_value;
                        state            <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        flags.frame_err <= flags.frame_err | ~bit_value;
                        all_zero        <= all_zero & ~bit_value;
                        if (bit_idx == 4'(stopBits - 1)) begin
                            if (all_zero && !bit_value) begin
                                brk   <= 1'b1;
                                state <= ST_BRKWAIT;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_BRKWAIT: begin
                    if (level) begin
                        brk   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clkRx or posedge i_rstRx) begin
        if (i_rstRx) begin
            o_rxData      <= '0;
            o_rxValid     <= 1'b0;
            o_parityError <= 1'b0;
            o_frameError  <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (complete) begin
                if (!o_rxValid || i_rxReady) begin
                    o_rxData      <= shift;
                    o_rxValid     <= 1'b1;
                    o_parityError <= frame_flags.parity_err;
                    o_frameError  <= frame_flags.frame_err;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_rxValid && i_rxReady) begin
                o_rxValid <= 1'b0;
            end
        end
    end

    assign o_break = brk;
    assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (default and 7O2 instances)
module tb_uart_rx_param;

    localparam int N = 16;

    typedef struct {
        logic [8:0] data;
        bit         perr;
        bit         ferr;
        int         t_fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst1, rst2, line1, line2, ready1, ready2;
    logic [7:0] data1;
    logic [6:0] data2;
    logic       valid1, perr1, ferr1, brk1, ovr1, busy1;
    logic       valid2, perr2, ferr2, brk2, ovr2, busy2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_fall = 0;
    int   ovr_cnt1 = 0;
    int   ovr_cyc1 = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t cur1, cur2;
    bit   pv1, pa1, pv2, pa2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param dut1 (
        .i_clkRx(clk), .i_rstRx(rst1), .i_rxLine(line1), .o_rxData(data1),
        .o_rxValid(valid1), .i_rxReady(ready1), .o_parityError(perr1),
        .o_frameError(ferr1), .o_break(brk1), .o_overrun(ovr1), .o_busy(busy1)
    );

    uart_rx_param #(.clksPerBit(N), .dataBits(7), .parityMode(2), .stopBits(2)) dut2 (
        .i_clkRx(clk), .i_rstRx(rst2), .i_rxLine(line2), .o_rxData(data2),
        .o_rxValid(valid2), .i_rxReady(ready2), .o_parityError(perr2),
        .o_frameError(ferr2), .o_break(brk2), .o_overrun(ovr2), .o_busy(busy2)
    );

    // Falling edge of start to first valid cycle, as stated for the block.
    function automatic int lat(input int n, input int d, input int p, input int s);
        return (1 + d + ((p != 0) ? 1 : 0) + s) * n - n / 2 + 4;
    endfunction

    // Parity bit a correct transmitter sends: even -> total ones even, odd -> total ones odd.
    function automatic bit rule_parity(input logic [8:0] data, input int d, input int pmode);
        int ones = 0;
        for (int i = 0; i < d; i++) ones += int'(data[i]);
        return (pmode == 1) ? bit'(ones % 2) : bit'((ones % 2) == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_window(input string name, input int act, input int centre);
        n_checks++;
        if (act < centre - 2 || act > centre + 2) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/-2", name, act, centre);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) line1 = v;
        else          line2 = v;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input bit flip_par,
                              input logic [1:0] stops, input bit deliver);
        int   d, p, s;
        bit   pbit;
        exp_t e;
        d = (sel == 0) ? 8 : 7;
        p = (sel == 0) ? 1 : 2;
        s = (sel == 0) ? 1 : 2;
        pbit     = rule_parity(data, d, p) ^ flip_par;
        e.data   = data & ((9'd1 << d) - 9'd1);
        e.perr   = flip_par;
        e.ferr   = 1'b0;
        for (int i = 0; i < s; i++) if (!stops[i]) e.ferr = 1'b1;
        e.t_fall  = cyc;
        last_fall = cyc;
        if (deliver) begin
            if (sel == 0) q1.push_back(e);
            else          q2.push_back(e);
        end
        set_line(sel, 1'b0);
        wait_cycles(N);
        for (int i = 0; i < d; i++) begin
            set_line(sel, data[i]);
            wait_cycles(N);
        end
        if (p != 0) begin
            set_line(sel, pbit);
            wait_cycles(N);
        end
        for (int i = 0; i < s; i++) begin
            set_line(sel, stops[i]);
            wait_cycles(N);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got valid frame %0h expected no frame", name, act);
    endtask

    // Compare process: every valid cycle against the expected-frame queues.
    initial begin
        cur1 = '{data: 9'd0, perr: 1'b0, ferr: 1'b0, t_fall: 0};
        cur2 = cur1;
        forever begin
            @(negedge clk);
            if (rst1) begin
                pv1 = 1'b0;
                pa1 = 1'b0;
            end else begin
                if (valid1 && (!pv1 || pa1)) begin
                    if (q1.size() == 0) unexpected("dut1 frame", {24'd0, data1});
                    else begin
                        cur1 = q1.pop_front();
                        chk_window("dut1 latency", cyc - cur1.t_fall, lat(N, 8, 1, 1));
                    end
                end
                if (valid1) begin
                    chk("dut1 data", {24'd0, data1}, {23'd0, cur1.data});
                    chk("dut1 parity flag", {31'd0, perr1}, {31'd0, cur1.perr});
                    chk("dut1 frame flag", {31'd0, ferr1}, {31'd0, cur1.ferr});
                end
                if (ovr1) begin
                    ovr_cnt1++;
                    ovr_cyc1 = cyc;
                end
                pv1 = valid1;
                pa1 = valid1 && ready1;
            end
            if (rst2) begin
                pv2 = 1'b0;
                pa2 = 1'b0;
            end else begin
                if (valid2 && (!pv2 || pa2)) begin
                    if (q2.size() == 0) unexpected("dut2 frame", {25'd0, data2});
                    else begin
                        cur2 = q2.pop_front();
                        chk_window("dut2 latency", cyc - cur2.t_fall, lat(N, 7, 2, 2));
                    end
                end
                if (valid2) begin
                    chk("dut2 data", {25'd0, data2}, {23'd0, cur2.data});
                    chk("dut2 parity flag", {31'd0, perr2}, {31'd0, cur2.perr});
                    chk("dut2 frame flag", {31'd0, ferr2}, {31'd0, cur2.ferr});
                end
                pv2 = valid2;
                pa2 = valid2 && ready2;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int hi_cnt;
        int t2;
        rst1 = 1'b1; rst2 = 1'b1;
        line1 = 1'b1; line2 = 1'b1;
        ready1 = 1'b1; ready2 = 1'b1;

        chk("model latency 8E1", lat(N, 8, 1, 1), 172);
        chk("model even parity A5", {31'd0, rule_parity(9'h0A5, 8, 1)}, 0);
        chk("model odd parity 55", {31'd0, rule_parity(9'h055, 7, 2)}, 1);

        wait_cycles(3);
        chk("reset valid", {31'd0, valid1}, 0);
        chk("reset data", {24'd0, data1}, 0);
        chk("reset flags", {28'd0, perr1, ferr1, brk1, ovr1}, 0);
        chk("reset busy", {31'd0, busy1}, 0);
        rst1 = 1'b0; rst2 = 1'b0;
        wait_cycles(5);

        // 1: clean frame
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
        wait_cycles(30);

        // 2: parity error, then framing error
        send_frame(0, 9'h0A5, 1'b1, 2'b11, 1'b1);
        wait_cycles(30);
        send_frame(0, 9'h0A5, 1'b0, 2'b00, 1'b1);
        wait_cycles(40);

        // 3: overrun with consumer stalled
        ready1 = 1'b0;
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b0);
        t2 = last_fall;
        wait_cycles(10);
        chk("overrun pulse count", ovr_cnt1, 1);
        chk_window("overrun timing", ovr_cyc1 - t2, lat(N, 8, 1, 1));
        chk("held valid", {31'd0, valid1}, 1);
        chk("held data", {24'd0, data1}, 32'h3C);
        ready1 = 1'b1;
        wait_cycles(2);
        chk("valid cleared after ready", {31'd0, valid1}, 0);
        wait_cycles(20);

        // 4: glitch
        line1 = 1'b0;
        wait_cycles(4);
        line1 = 1'b1;
        chk("glitch busy", {31'd0, busy1}, 1);
        waited = -1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (!busy1) begin
                waited = i;
                break;
            end
        end
        chk("glitch busy clears", {31'd0, waited >= 0}, 1);
        chk("glitch flags", {29'd0, valid1, brk1, ovr1}, 0);
        wait_cycles(20);

        // 5: break
        line1 = 1'b0;
        wait_cycles(160);
        chk("break not yet", {31'd0, brk1}, 0);
        wait_cycles(32);
        chk("break set", {31'd0, brk1}, 1);
        line1 = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (brk1) hi_cnt++;
            else break;
        end
        chk("break clear delay", hi_cnt, 3);
        wait_cycles(5);
        chk("break busy", {31'd0, busy1}, 0);
        wait_cycles(20);

        // 6: 7 data bits, odd parity, 2 stop bits, reset mid-frame
        send_frame(1, 9'h055, 1'b0, 2'b11, 1'b1);
        wait_cycles(30);
        send_frame(1, 9'h07F, 1'b1, 2'b11, 1'b1);
        wait_cycles(30);
        line2 = 1'b0;
        wait_cycles(N);
        line2 = 1'b1;
        wait_cycles(N);
        line2 = 1'b0;
        wait_cycles(N + N / 2);
        rst2  = 1'b1;
        line2 = 1'b1;
        wait_cycles(3);
        chk("dut2 reset data", {25'd0, data2}, 0);
        chk("dut2 reset outputs", {26'd0, valid2, perr2, ferr2, brk2, ovr2, busy2}, 0);
        rst2 = 1'b0;
        wait_cycles(250);
        chk("dut2 idle after reset", {31'd0, busy2}, 0);
        send_frame(1, 9'h02A, 1'b0, 2'b11, 1'b1);
        wait_cycles(30);

        chk("dut1 frames outstanding", q1.size(), 0);
        chk("dut2 frames outstanding", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
